// File: rtl/common.sv
// Shared core constants and instruction-bus transaction types.
package common;

  localparam logic [63:0] PC_INIT = 64'h8000_0000;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

endpackage

// File: rtl/pipes.sv
// Pipeline-register payload types and the fetch controller state encoding.
package pipes;

  typedef struct packed {
    logic [31:0] raw_instr;
    logic [63:0] pc;
    logic        is_bubble;
  } fetch_data_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam fetch_data_t FETCH_BUBBLE = '{raw_instr: 32'd0, pc: 64'd0, is_bubble: 1'b1};

  function automatic fetch_data_t mk_instr(input logic [31:0] instr, input logic [63:0] pc);
    return '{raw_instr: instr, pc: pc, is_bubble: 1'b0};
  endfunction

endpackage

// File: rtl/pcselect.sv
// Next-PC selection for the fetch stage: sequential, redirect target, or
// the target parked while a wrong-path request drains.
module pcselect
  import pipes::*;
(
  input  fetch_state_t i_state,
  input  logic [63:0]  i_pc,
  input  logic         i_redir,
  input  logic [63:0]  i_tgt,
  input  logic [63:0]  i_tgt_r,
  input  logic         i_data_ok,
  output logic [63:0]  o_pc_next
);

  always_comb begin
    o_pc_next = i_pc;
    case (i_state)
      FETCH: begin
        if (i_data_ok && i_redir) o_pc_next = i_tgt;
        else if (i_data_ok)       o_pc_next = i_pc + 64'd4;
      end
      HOLD: begin
        if (i_redir) o_pc_next = i_tgt;
      end
      FLUSH: begin
        // pc keeps addressing the in-flight request until it completes
        if (i_data_ok) o_pc_next = i_tgt_r;
      end
      default: o_pc_next = i_pc;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding ibus reads, stall buffering and
// wrong-path squashing. FETCH_PERF_EN adds fetch/squash event counters.
module fetch_stage
  import pipes::*;
#(
  parameter logic [63:0] PC_INIT = common::PC_INIT
) (
  input  logic               clk,
  input  logic               reset,
  output common::ibus_req_t  ireq,
  input  common::ibus_resp_t iresp,
  output fetch_data_t        dataF,
  input  logic               stall,
  input  logic               is_jump,
  input  logic [63:0]        offset
`ifdef FETCH_PERF_EN
  ,
  output logic [63:0]        perf_fetch,
  output logic [63:0]        perf_squash
`endif
);

  fetch_state_t r_state;
  logic [63:0]  r_pc;
  logic [63:0]  r_tgt;
  logic [31:0]  r_buf_instr;
  logic [63:0]  r_buf_pc;
  fetch_data_t  r_data;

  logic         w_redir;
  logic [63:0]  w_tgt;
  logic [63:0]  w_pc_next;
  logic         w_valid;
  logic         w_unused_addr_ok;

  assign w_unused_addr_ok = iresp.addr_ok;

  assign w_redir = is_jump && !stall && !r_data.is_bubble;
  assign w_tgt   = r_data.pc + offset;

  // The bus is treated as reset together with the core, so no request is shown while reset is high
  assign w_valid    = !reset && (r_state != HOLD);
  assign ireq.valid = w_valid;
  assign ireq.addr  = w_valid ? r_pc : 64'd0;
  assign dataF      = r_data;

  pcselect u_pcselect (
    .i_state   (r_state),
    .i_pc      (r_pc),
    .i_redir   (w_redir),
    .i_tgt     (w_tgt),
    .i_tgt_r   (r_tgt),
    .i_data_ok (iresp.data_ok),
    .o_pc_next (w_pc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= FETCH;
      r_pc        <= PC_INIT;
      r_tgt       <= 64'd0;
      r_buf_instr <= 32'd0;
      r_buf_pc    <= 64'd0;
      r_data      <= FETCH_BUBBLE;
    end else begin
      r_pc <= w_pc_next;
      // Default when decode accepts: a bubble, overridden below on delivery
      if (!stall) r_data <= FETCH_BUBBLE;
      case (r_state)
        FETCH: begin
          if (iresp.data_ok) begin
            if (!w_redir) begin
              if (!stall) begin
                r_data <= mk_instr(iresp.data, r_pc);
              end else begin
                r_buf_instr <= iresp.data;
                r_buf_pc    <= r_pc;
                r_state     <= HOLD;
              end
            end
          end else if (w_redir) begin
            r_tgt   <= w_tgt;
            r_state <= FLUSH;
          end
        end
        HOLD: begin
          if (w_redir) begin
            r_state <= FETCH;
          end else if (!stall) begin
            r_data  <= mk_instr(r_buf_instr, r_buf_pc);
            r_state <= FETCH;
          end
        end
        FLUSH: begin
          if (iresp.data_ok) r_state <= FETCH;
        end
        default: r_state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic w_deliver;
  logic w_squash;

  assign w_deliver = !stall && !w_redir &&
                     (((r_state == FETCH) && iresp.data_ok) || (r_state == HOLD));
  assign w_squash  = ((r_state == FETCH) && iresp.data_ok && w_redir) ||
                     ((r_state == HOLD) && w_redir) ||
                     ((r_state == FLUSH) && iresp.data_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch  <= 64'd0;
      perf_squash <= 64'd0;
    end else begin
      if (w_deliver) perf_fetch  <= perf_fetch + 64'd1;
      if (w_squash)  perf_squash <= perf_squash + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus a mid-flight reset sequence.
module tb_fetch_stage;
  import pipes::*;

  logic               clk;
  logic               reset;
  common::ibus_req_t  ireq;
  common::ibus_resp_t iresp;
  fetch_data_t        dataF;
  logic               stall;
  logic               is_jump;
  logic [63:0]        offset;
`ifdef FETCH_PERF_EN
  logic [63:0]        perf_fetch;
  logic [63:0]        perf_squash;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int lat = 0;
  int cnt = 0;

  localparam logic [63:0] BASE = 64'h8000_0000;

  fetch_stage dut (
    .clk     (clk),
    .reset   (reset),
    .ireq    (ireq),
    .iresp   (iresp),
    .dataF   (dataF),
    .stall   (stall),
    .is_jump (is_jump),
    .offset  (offset)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch  (perf_fetch),
    .perf_squash (perf_squash)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus model: answers addr[31:0] after 'lat' wait cycles of a held request
  always_comb begin
    iresp         = '0;
    iresp.addr_ok = ireq.valid;
    iresp.data_ok = ireq.valid && (cnt >= lat);
    iresp.data    = ireq.addr[31:0];
  end

  always @(posedge clk) begin
    if (reset || !ireq.valid || iresp.data_ok) cnt <= 0;
    else cnt <= cnt + 1;
  end

  typedef struct {
    logic        stall;
    logic        jmp;
    logic [63:0] off;
    int          lat;
    logic        ev;
    logic [63:0] ea;
    logic        eb;
    logic [63:0] epc;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t v(input logic s, input logic j, input logic [63:0] o, input int l,
                             input logic ev, input logic [63:0] ea, input logic eb,
                             input logic [63:0] epc);
    return '{stall: s, jmp: j, off: o, lat: l, ev: ev, ea: ea, eb: eb, epc: epc};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_dataf(input string tag, input logic eb, input logic [63:0] epc);
    logic [63:0] eraw;
    eraw = eb ? 64'd0 : {32'd0, epc[31:0]};
    chk({tag, " bubble"}, {63'd0, dataF.is_bubble}, {63'd0, eb});
    chk({tag, " pc"}, dataF.pc, epc);
    chk({tag, " raw"}, {32'd0, dataF.raw_instr}, eraw);
  endtask

  initial begin
    // stall, jmp, offset, lat | valid, addr, bubble, dataF.pc
    vecs[0]  = v(0, 0, 64'd0, 0, 1, BASE + 64'h00, 1, 64'd0);
    vecs[1]  = v(0, 0, 64'd0, 0, 1, BASE + 64'h04, 0, BASE + 64'h00);
    vecs[2]  = v(1, 0, 64'd0, 0, 1, BASE + 64'h08, 0, BASE + 64'h04);
    vecs[3]  = v(1, 0, 64'd0, 0, 0, 64'd0,         0, BASE + 64'h04);
    vecs[4]  = v(1, 0, 64'd0, 0, 0, 64'd0,         0, BASE + 64'h04);
    vecs[5]  = v(1, 0, 64'd0, 0, 0, 64'd0,         0, BASE + 64'h04);
    vecs[6]  = v(0, 0, 64'd0, 0, 0, 64'd0,         0, BASE + 64'h04);
    vecs[7]  = v(0, 0, 64'd0, 2, 1, BASE + 64'h0C, 0, BASE + 64'h08);
    vecs[8]  = v(0, 0, 64'd0, 2, 1, BASE + 64'h0C, 1, 64'd0);
    vecs[9]  = v(0, 0, 64'd0, 2, 1, BASE + 64'h0C, 1, 64'd0);
    vecs[10] = v(0, 0, 64'd0, 0, 1, BASE + 64'h10, 0, BASE + 64'h0C);
    vecs[11] = v(0, 1, -64'sd16, 0, 1, BASE + 64'h14, 0, BASE + 64'h10);
    vecs[12] = v(0, 0, 64'd0, 0, 1, BASE + 64'h00, 1, 64'd0);
    vecs[13] = v(0, 0, 64'd0, 0, 1, BASE + 64'h04, 0, BASE + 64'h00);
    vecs[14] = v(0, 0, 64'd0, 0, 1, BASE + 64'h08, 0, BASE + 64'h04);
    vecs[15] = v(0, 0, 64'd0, 0, 1, BASE + 64'h0C, 0, BASE + 64'h08);
    vecs[16] = v(0, 0, 64'd0, 0, 1, BASE + 64'h10, 0, BASE + 64'h0C);
    vecs[17] = v(0, 1, 64'h40, 2, 1, BASE + 64'h14, 0, BASE + 64'h10);
    vecs[18] = v(0, 0, 64'd0, 2, 1, BASE + 64'h14, 1, 64'd0);
    vecs[19] = v(0, 0, 64'd0, 2, 1, BASE + 64'h14, 1, 64'd0);
    vecs[20] = v(0, 0, 64'd0, 0, 1, BASE + 64'h50, 1, 64'd0);
    vecs[21] = v(0, 0, 64'd0, 0, 1, BASE + 64'h54, 0, BASE + 64'h50);

    reset   = 1'b1;
    stall   = 1'b0;
    is_jump = 1'b0;
    offset  = 64'd0;
    lat     = 0;

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset valid", {63'd0, ireq.valid}, 64'd0);
    chk("reset addr", ireq.addr, 64'd0);
    chk_dataf("reset dataF", 1'b1, 64'd0);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      reset   = 1'b0;
      stall   = vecs[i].stall;
      is_jump = vecs[i].jmp;
      offset  = vecs[i].off;
      lat     = vecs[i].lat;
      #1;
      chk($sformatf("c%0d valid", i), {63'd0, ireq.valid}, {63'd0, vecs[i].ev});
      if (vecs[i].ev) chk($sformatf("c%0d addr", i), ireq.addr, vecs[i].ea);
      chk_dataf($sformatf("c%0d dataF", i), vecs[i].eb, vecs[i].epc);
    end

    // Redirect into FLUSH, then reset while the wrong-path request is pending
    @(negedge clk);
    lat = 2; is_jump = 1'b1; offset = 64'd8;
    #1;
    chk("c22 addr", ireq.addr, BASE + 64'h58);
    chk_dataf("c22 dataF", 1'b0, BASE + 64'h54);

    @(negedge clk);
    is_jump = 1'b0; offset = 64'd0;
    #1;
    chk("c23 flush valid", {63'd0, ireq.valid}, 64'd1);
    chk("c23 flush addr", ireq.addr, BASE + 64'h58);
    chk_dataf("c23 dataF", 1'b1, 64'd0);

    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("c24 reset valid", {63'd0, ireq.valid}, 64'd0);
`ifdef FETCH_PERF_EN
    chk("perf_fetch", perf_fetch, 64'd12);
    chk("perf_squash", perf_squash, 64'd2);
`endif

    @(negedge clk);
    #1;
    chk("c25 reset valid", {63'd0, ireq.valid}, 64'd0);
    chk_dataf("c25 dataF", 1'b1, 64'd0);
`ifdef FETCH_PERF_EN
    chk("perf_fetch cleared", perf_fetch, 64'd0);
    chk("perf_squash cleared", perf_squash, 64'd0);
`endif

    @(negedge clk);
    reset = 1'b0; lat = 0;
    #1;
    chk("c26 valid", {63'd0, ireq.valid}, 64'd1);
    chk("c26 addr", ireq.addr, BASE);
    chk_dataf("c26 dataF", 1'b1, 64'd0);

    @(negedge clk);
    #1;
    chk("c27 addr", ireq.addr, BASE + 64'h04);
    chk_dataf("c27 dataF", 1'b0, BASE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the five-stage pipeline. Owns the PC, issues single-outstanding reads on the instruction bus, and registers each returned instruction into `dataF` for the decode stage. Applies branch/JAL redirects signalled by decode one cycle after the decision. Squashes any wrong-path fetch that is already in flight.

## Interface
- `PC_INIT`, default `64'h8000_0000`: PC of the first fetch after reset.
- `clk` input, 1: clock.
- `reset` input, 1: synchronous, active-high.
- `ireq` output, `ibus_req_t`: `valid`, `addr` (64).
- `iresp` input, `ibus_resp_t`: `data_ok`, `data` (32). `addr_ok` is ignored.
- `dataF` output, `fetch_data_t`: registered `raw_instr` (32), `pc` (64), `is_bubble` (1).
- `stall` input, 1: decode cannot accept; `dataF` must hold.
- `is_jump` input, 1: decode's taken branch/JAL flag for the current `dataF`.
- `offset` input, 64: sign-extended branch/JAL offset from decode.

## Operation
- Redirect event `redir = is_jump && !stall && !dataF.is_bubble`. Target `tgt = dataF.pc + offset`, modulo 2^64. No alignment check; the address is issued as-is.
- Bus rule: once `ireq.valid` rises, `addr` stays stable and `valid` stays high until the cycle `data_ok` = 1. There is one request in flight at a time.
- States:
  - FETCH: `valid`=1, `addr`=pc.
    - `data_ok && redir`: discard data; pc←tgt; stay in FETCH.
    - `data_ok && !stall`: dataF←{data, pc, 0}; pc←pc+4.
    - `data_ok && stall`: buf←{data, pc}; pc←pc+4; go to HOLD.
    - `!data_ok && redir`: tgt_r←tgt; go to FLUSH.
  - HOLD: `valid`=0.
    - `redir`: discard buf; pc←tgt; go to FETCH.
    - else `!stall`: dataF←{buf, 0}; go to FETCH.
  - FLUSH: `valid`=1, `addr`=old pc.
    - On `data_ok`: discard data; pc←tgt_r; go to FETCH.
- `dataF` update rules:
  - `stall`=1: holds, except on a `redir` cycle, which by definition has `stall`=0.
  - `stall`=0 with no instruction delivered: loads a bubble (`is_bubble`=1, `raw_instr`=0, `pc`=0).
- `redir` cannot fire in FLUSH, because `dataF` is then a bubble.

## Timing
- Reset values:
  - state FETCH, pc=`PC_INIT`.
  - `ireq.valid`=0 and `ireq.addr`=0 during the reset cycle.
  - `dataF`={0, 0, 1}; buf and tgt_r = 0.
- First request: `valid`=1 with `addr`=`PC_INIT` in the first cycle after reset deasserts.
- `data_ok` in cycle t (FETCH, no stall, no redir): the instruction appears on `dataF` in cycle t+1.
- Next request: with `data_ok` in cycle t, the next request is on the bus in cycle t+1. This gives 1 instr/cycle with a zero-wait bus.
- Redirect penalty:
  - `redir` in cycle t: `dataF` is a bubble at t+1.
  - The request for `tgt` is issued at t+1 if `data_ok` came at t, or in the cycle after `data_ok` if in FLUSH.
- `reset` mid-operation: all state returns to reset values next cycle. A pending bus transaction is abandoned and the bus is assumed reset with the core.

## Configuration
- `FETCH_PERF_EN`:
  - Defined: adds outputs `perf_fetch` (64), which counts delivered non-bubble instructions, and `perf_squash` (64), which counts discarded bus responses in FETCH, HOLD and FLUSH. Both are cleared on `reset` and wrap at 2^64.
  - Undefined: neither the ports nor the counters exist. Behaviour is otherwise identical.

## Structure
- `pipes` package:
  - `fetch_data_t` (existing).
  - New enum `fetch_state_t` {FETCH, HOLD, FLUSH}.
- `common` package: `PC_INIT` default constant, `ibus_req_t` and `ibus_resp_t`.
- One combinational sub-module, `pcselect`:
  - Inputs: state, pc, `redir`, `tgt`, tgt_r, `data_ok`.
  - Output: next pc.
  - The top module holds the FSM, buf and the `dataF` register.

## Test plan
- **Reset and straight-line fetch.** Zero-wait bus returning `addr[31:0]` as data.
  - `ireq.addr` is 8000_0000, 8000_0004, … on consecutive cycles.
  - `dataF.pc` lags by one cycle with `is_bubble`=0.
- **Bus latency.** `data_ok` 3 cycles after `valid`.
  - `addr` is stable for 3 cycles.
  - `dataF` shows 2 bubbles, then the instruction.
- **Stall with buffering.**
  - Stimulus: `stall`=1 for 4 cycles starting in the same cycle as `data_ok` for 8000_0008.
  - Required: `dataF` holds 8000_0004; `valid`=0 in HOLD; after `stall` drops, `dataF`=8000_0008, then the request for 8000_000C.
- **Redirect with data_ok in the same cycle.**
  - Stimulus: `dataF.pc`=8000_0010, `is_jump`=1, `offset`=-16.
  - Required: the 8000_0014 response is discarded; next `addr`=8000_0000; `dataF` is a bubble for one cycle.
- **Redirect while a request is outstanding.**
  - Stimulus: `redir` with `offset`=0x40 while the request for 8000_0014 awaits `data_ok`.
  - Required: FLUSH holds `addr`=8000_0014 until `data_ok`; that data never appears on `dataF`; the next `addr` is 8000_0050; `perf_squash`=1 when `FETCH_PERF_EN` is defined.
- **Reset mid-flight.** Assert `reset` during FLUSH.
  - Next cycle `valid`=0 and `dataF.is_bubble`=1.
  - Fetching restarts at `PC_INIT`.
